// File: rtl/tanh_inv_pkg.sv
// Shared definitions for the 4-bit approximate-tanh inverse search.
// Contents: FSM state enum, code width, last sweep index, result payload
// struct and the 4-bit absolute-difference helper.
package tanh_inv_pkg;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] SWEEP_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result payload presented on the output handshake.
  typedef struct packed {
    logic [W-1:0] x;
    logic         exact;
    logic [W-1:0] err;
  } res_t;

  // |a-b| computed as larger minus smaller, so it never underflows.
  function automatic logic [W-1:0] abs_diff4(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    return (a > b) ? W'(a - b) : W'(b - a);
  endfunction

endpackage

// File: rtl/tanh_fwd_approx_4bit.sv
// Combinational forward model of the 4-bit approximate tanh: o_f = f(i_x).
// Ports:
//   i_x  4-bit input code
//   o_f  4-bit approximate tanh output code
module tanh_fwd_approx_4bit
  import tanh_inv_pkg::*;
(
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_f
);

  // Forward lookup table.
  always_comb begin
    o_f = '0;
    unique case (i_x)
      4'd0:  o_f = 4'd0;
      4'd1:  o_f = 4'd3;
      4'd2:  o_f = 4'd12;
      4'd3:  o_f = 4'd3;
      4'd4:  o_f = 4'd8;
      4'd5:  o_f = 4'd3;
      4'd6:  o_f = 4'd12;
      4'd7:  o_f = 4'd15;
      4'd8:  o_f = 4'd0;
      4'd9:  o_f = 4'd3;
      4'd10: o_f = 4'd12;
      4'd11: o_f = 4'd11;
      4'd12: o_f = 4'd4;
      4'd13: o_f = 4'd3;
      4'd14: o_f = 4'd12;
      4'd15: o_f = 4'd15;
      default: o_f = '0;
    endcase
  end

endmodule

// File: rtl/tanh_inverse_search_4bit.sv
// Sequential inverse of the 4-bit approximate tanh. For a target code y it
// sweeps x=0..15 through the forward model, one candidate per cycle, and
// returns the smallest x with f(x)==y, or else the smallest x minimising
// |f(x)-y|.
// Build option: define TANH_INV_EARLY_EXIT_EN to end the sweep on the first
// exact match (results are unchanged, only latency shrinks).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake, in_code = target y
//   out_valid/out_ready   result handshake
//   out_x, out_exact, out_err  found x, f(x)==y flag, |f(x)-y|
//   busy                  high while sweeping or holding a result
module tanh_inverse_search_4bit
  import tanh_inv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         out_exact,
  output logic [W-1:0] out_err,
  output logic         busy
);

  state_t       r_state,    w_state_n;
  logic [W-1:0] r_idx,      w_idx_n;
  logic [W-1:0] r_target,   w_target_n;
  logic [W-1:0] r_best_x,   w_best_x_n;
  logic [W-1:0] r_best_err, w_best_err_n;
  res_t         r_res,      w_res_n;
  logic         r_out_valid, w_out_valid_n;
  logic         r_in_ready,  w_in_ready_n;
  logic         r_busy,      w_busy_n;

  logic [W-1:0] w_f;
  logic [W-1:0] w_d;
  logic [W-1:0] w_cand_x;
  logic [W-1:0] w_cand_err;
  logic         w_better;
  logic         w_last;

  tanh_fwd_approx_4bit u_fwd (
    .i_x (r_idx),
    .o_f (w_f)
  );

  // Candidate evaluation; strict compare keeps the smaller x on ties.
  assign w_d        = abs_diff4(w_f, r_target);
  assign w_better   = (w_d < r_best_err);
  assign w_cand_x   = w_better ? r_idx : r_best_x;
  assign w_cand_err = w_better ? w_d   : r_best_err;

`ifdef TANH_INV_EARLY_EXIT_EN
  // The first exact hit is already the smallest x, so stopping is safe.
  assign w_last = (r_idx == SWEEP_LAST) || (w_d == '0);
`else
  assign w_last = (r_idx == SWEEP_LAST);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_target    <= '0;
      r_best_x    <= '0;
      r_best_err  <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_target    <= w_target_n;
      r_best_x    <= w_best_x_n;
      r_best_err  <= w_best_err_n;
      r_res       <= w_res_n;
      r_out_valid <= w_out_valid_n;
      r_in_ready  <= w_in_ready_n;
      r_busy      <= w_busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_n     = r_state;
    w_idx_n       = r_idx;
    w_target_n    = r_target;
    w_best_x_n    = r_best_x;
    w_best_err_n  = r_best_err;
    w_res_n       = r_res;
    w_out_valid_n = r_out_valid;
    w_in_ready_n  = r_in_ready;
    w_busy_n      = r_busy;

    unique case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_state_n    = SWEEP;
          w_target_n   = in_code;
          w_idx_n      = '0;
          w_best_x_n   = '0;
          w_best_err_n = 4'd15;
          w_in_ready_n = 1'b0;
          w_busy_n     = 1'b1;
        end
      end
      SWEEP: begin
        w_best_x_n   = w_cand_x;
        w_best_err_n = w_cand_err;
        if (w_last) begin
          w_state_n     = DONE;
          w_out_valid_n = 1'b1;
          w_res_n.x     = w_cand_x;
          w_res_n.err   = w_cand_err;
          w_res_n.exact = (w_cand_err == '0);
        end else begin
          w_idx_n = W'(r_idx + 4'd1);
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_n     = IDLE;
          w_out_valid_n = 1'b0;
          w_in_ready_n  = 1'b1;
          w_busy_n      = 1'b0;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_x     = r_res.x;
  assign out_exact = r_res.exact;
  assign out_err   = r_res.err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tanh_inverse_search_4bit.sv
// Self-checking bench for tanh_inverse_search_4bit: directed vector table,
// hand-written reset/hold corner cases and randomized requests against a
// search model over the forward table.
module tb_tanh_inverse_search_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_x;
  logic       out_exact;
  logic [3:0] out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int f_tab[16] = '{0, 3, 12, 3, 8, 3, 12, 15, 0, 3, 12, 11, 4, 3, 12, 15};

  typedef struct {
    logic [3:0] y;
    logic [3:0] x;
    bit         exact;
    logic [3:0] err;
    int         lat_full;
    int         lat_early;
    int         hold;
  } vec_t;

  vec_t vecs[9];

  tanh_inverse_search_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_exact (out_exact),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: brute-force scan for the smallest x with minimal |f(x)-y|.
  task automatic ref_search(input int y, output int x, output int err,
                            output int lat);
    int best;
    int first_exact;
    best = 100;
    x = 0;
    first_exact = -1;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = (f_tab[i] > y) ? f_tab[i] - y : y - f_tab[i];
      if (d < best) begin
        best = d;
        x = i;
      end
      if (d == 0 && first_exact < 0) first_exact = i;
    end
    err = best;
`ifdef TANH_INV_EARLY_EXIT_EN
    lat = (first_exact >= 0) ? first_exact + 1 : 16;
`else
    lat = 16;
`endif
  endtask

  // One request: accept at edge E0, measure edges until out_valid, optionally
  // withhold out_ready for 'hold' cycles, then complete the handshake.
  task automatic do_req(input string tag, input logic [3:0] y, input int hold,
                        input bit noisy, output int lat, output logic [3:0] x,
                        output bit ex, output logic [3:0] err);
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, int'(in_ready), 1);
    in_valid  = 1'b1;
    in_code   = y;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    if (!noisy) in_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (noisy) in_code = 4'($urandom_range(0, 15));
      if (lat == 1) begin
        chk({tag, "_in_ready_busy"}, int'(in_ready), 0);
        chk({tag, "_busy"}, int'(busy), 1);
      end
      if (out_valid) break;
      if (lat > 40) begin
        errors++;
        $display("FAIL %s_timeout: got no out_valid expected within 40", tag);
        break;
      end
    end
    x   = out_x;
    ex  = out_exact;
    err = out_err;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_x"}, int'(out_x), int'(x));
      chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_fall"}, int'(out_valid), 0);
    chk({tag, "_in_ready_back"}, int'(in_ready), 1);
    chk({tag, "_busy_fall"}, int'(busy), 0);
  endtask

  initial begin
    int         lat;
    int         rx;
    int         rerr;
    int         rlat;
    logic [3:0] gx;
    logic [3:0] gerr;
    bit         gex;

    vecs[0] = '{4'd3,  4'd1,  1'b1, 4'd0, 16, 2,  0};
    vecs[1] = '{4'd11, 4'd11, 1'b1, 4'd0, 16, 12, 0};
    vecs[2] = '{4'd5,  4'd12, 1'b0, 4'd1, 16, 16, 0};
    vecs[3] = '{4'd7,  4'd4,  1'b0, 4'd1, 16, 16, 0};
    vecs[4] = '{4'd15, 4'd7,  1'b1, 4'd0, 16, 8,  5};
    vecs[5] = '{4'd0,  4'd0,  1'b1, 4'd0, 16, 1,  0};
    vecs[6] = '{4'd12, 4'd2,  1'b1, 4'd0, 16, 3,  0};
    vecs[7] = '{4'd4,  4'd12, 1'b1, 4'd0, 16, 13, 0};
    vecs[8] = '{4'd9,  4'd4,  1'b0, 4'd1, 16, 16, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_exact", int'(out_exact), 0);
    chk("rst_out_err", int'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].y, vecs[i].hold, 1'b0,
             lat, gx, gex, gerr);
      chk($sformatf("vec%0d_x", i), int'(gx), int'(vecs[i].x));
      chk($sformatf("vec%0d_exact", i), int'(gex), int'(vecs[i].exact));
      chk($sformatf("vec%0d_err", i), int'(gerr), int'(vecs[i].err));
`ifdef TANH_INV_EARLY_EXIT_EN
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat_early);
`else
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat_full);
`endif
    end

    // Reset pulse at E0+6 of a y=12 sweep.
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 4'd12;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_x", int'(out_x), 0);
    chk("midrst_out_err", int'(out_err), 0);
    chk("midrst_out_exact", int'(out_exact), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        chk("midrst_no_pulse", int'(out_valid), 0);
        break;
      end
    end
    chk("midrst_idle_busy", int'(busy), 0);
    do_req("after_rst", 4'd12, 0, 1'b0, lat, gx, gex, gerr);
    chk("after_rst_x", int'(gx), 2);
    chk("after_rst_exact", int'(gex), 1);

    // Noisy in_valid/in_code during the sweep must not disturb the result.
    do_req("noisy", 4'd5, 2, 1'b1, lat, gx, gex, gerr);
    chk("noisy_x", int'(gx), 12);
    chk("noisy_err", int'(gerr), 1);
    chk("noisy_lat", lat, 16);

    // Randomized requests against the reference search.
    for (int i = 0; i < 30; i++) begin
      logic [3:0] y;
      y = 4'($urandom_range(0, 15));
      ref_search(int'(y), rx, rerr, rlat);
      do_req($sformatf("rnd%0d", i), y, int'($urandom_range(0, 2)),
             bit'($urandom_range(0, 1)), lat, gx, gex, gerr);
      chk($sformatf("rnd%0d_x", i), int'(gx), rx);
      chk($sformatf("rnd%0d_err", i), int'(gerr), rerr);
      chk($sformatf("rnd%0d_exact", i), int'(gex), (rerr == 0) ? 1 : 0);
      chk($sformatf("rnd%0d_lat", i), lat, rlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
